// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package sram_bist_pkg;

   typedef enum logic [2:0] {StIdle, StSetup, StRun, StDrain, StDone} bist_state_e;

   localparam int unsigned NUM_ELEM = 6;

   localparam logic [2:0] ElemW0     = 3'd0;
   localparam logic [2:0] ElemR0W1   = 3'd1;
   localparam logic [2:0] ElemR1W0   = 3'd2;
   localparam logic [2:0] ElemDnR0W1 = 3'd3;
   localparam logic [2:0] ElemDnR1W0 = 3'd4;
   localparam logic [2:0] ElemR0     = 3'd5;
   localparam logic [2:0] LastElem   = 3'(NUM_ELEM - 1);

   function automatic logic elem_down(input logic [2:0] e);
      return (e == ElemDnR0W1) || (e == ElemDnR1W0);
   endfunction

   function automatic logic [1:0] elem_nops(input logic [2:0] e);
      return ((e == ElemW0) || (e == ElemR0)) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic elem_first_rd(input logic [2:0] e);
      return e != ElemW0;
   endfunction

   // Background bit replicated across the word: 0 -> D0, 1 -> D1.
   function automatic logic elem_rd_bg(input logic [2:0] e);
      return (e == ElemR1W0) || (e == ElemDnR1W0);
   endfunction

   function automatic logic elem_wr_bg(input logic [2:0] e);
      return (e == ElemR0W1) || (e == ElemDnR0W1);
   endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down address counter with terminal-address flag for the March sequencer.
module sram_bist_addr_gen #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic              load_down_i,
   input  logic              step_i,
   input  logic              down_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              term_o
);

   logic [ADDR_W-1:0] addr_d, addr_q;

   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = load_down_i ? '1 : '0;
      end else if (step_i) begin
         addr_d = down_i ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign term_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller driving the SRAM macro BIST port.
// Optional first-fail capture ports enabled by SRAM_BIST_FAIL_CAPTURE_EN.
module sram_march_bist_ctrl
   import sram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              A_CLK,
   input  logic              A_RST_N,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic              A_BIST_EN,
   output logic              A_BIST_MEN,
   output logic              A_BIST_WEN,
   output logic              A_BIST_REN,
   output logic [ADDR_W-1:0] A_BIST_ADDR,
   output logic [DATA_W-1:0] A_BIST_DIN,
   output logic [DATA_W-1:0] A_BIST_BM,
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_syndrome,
`endif
   input  logic [DATA_W-1:0] A_DOUT
);

   bist_state_e       state_d, state_q;
   logic [2:0]        elem_d, elem_q;
   logic              op_idx_d, op_idx_q;
   logic              fin_d, fin_q;
   logic              busy_d, busy_q, done_d, done_q, pass_d, pass_q;
   logic [CNT_W-1:0]  fail_cnt_d, fail_cnt_q;
   logic              en_d, en_q, men_d, men_q, wen_d, wen_q, ren_d, ren_q;
   logic [ADDR_W-1:0] bist_addr_d, bist_addr_q;
   logic [DATA_W-1:0] din_d, din_q, rexp_d, rexp_q;
   logic              cmp_vld_d, cmp_vld_q;
   logic [DATA_W-1:0] cmp_exp_d, cmp_exp_q;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
   logic [2:0]        op_elem_d, op_elem_q, cmp_elem_d, cmp_elem_q, fail_elem_d, fail_elem_q;
   logic [ADDR_W-1:0] cmp_addr_d, cmp_addr_q, fail_addr_d, fail_addr_q;
   logic [DATA_W-1:0] fail_syn_d, fail_syn_q;
`endif

   logic              ag_load, ag_load_dir, ag_step, emit, rd, mismatch;
   logic [ADDR_W-1:0] pos_addr;
   logic              pos_term;

   sram_bist_addr_gen #(
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .clk_i      (A_CLK),
      .rst_ni     (A_RST_N),
      .load_i     (ag_load),
      .load_down_i(ag_load_dir),
      .step_i     (ag_step),
      .down_i     (elem_down(elem_q)),
      .addr_o     (pos_addr),
      .term_o     (pos_term)
   );

   always_comb begin
      state_d     = state_q;
      elem_d      = elem_q;
      op_idx_d    = op_idx_q;
      fin_d       = fin_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_cnt_d  = fail_cnt_q;
      en_d        = en_q;
      men_d       = 1'b0;
      wen_d       = 1'b0;
      ren_d       = 1'b0;
      bist_addr_d = bist_addr_q;
      din_d       = din_q;
      rexp_d      = rexp_q;
      cmp_vld_d   = ren_q;
      cmp_exp_d   = rexp_q;
      ag_load     = 1'b0;
      ag_load_dir = 1'b0;
      ag_step     = 1'b0;
      emit        = 1'b0;
      rd          = 1'b0;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
      op_elem_d   = op_elem_q;
      cmp_elem_d  = op_elem_q;
      cmp_addr_d  = bist_addr_q;
      fail_elem_d = fail_elem_q;
      fail_addr_d = fail_addr_q;
      fail_syn_d  = fail_syn_q;
`endif

      // Read issued two edges ago, data now on A_DOUT.
      mismatch = cmp_vld_q && (A_DOUT != cmp_exp_q);
      if (mismatch) begin
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
         if (fail_cnt_q == '0) begin
            fail_elem_d = cmp_elem_q;
            fail_addr_d = cmp_addr_q;
            fail_syn_d  = cmp_exp_q ^ A_DOUT;
         end
`endif
         if (!(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (abort) begin
               state_d = StIdle;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (start) begin
               state_d     = StSetup;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_cnt_d  = '0;
               en_d        = 1'b1;
               elem_d      = ElemW0;
               op_idx_d    = 1'b0;
               fin_d       = 1'b0;
               ag_load     = 1'b1;
               ag_load_dir = elem_down(ElemW0);
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
               fail_elem_d = '0;
               fail_addr_d = '0;
               fail_syn_d  = '0;
`endif
            end
         end
         StSetup: begin
            emit    = 1'b1;
            state_d = StRun;
         end
         StRun: begin
            if (fin_q) state_d = StDrain;
            else       emit    = 1'b1;
         end
         StDrain: begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            en_d    = 1'b0;
            pass_d  = (fail_cnt_d == '0);
         end
         default: state_d = StIdle;
      endcase

      if (emit) begin
         rd          = elem_first_rd(elem_q) && !op_idx_q;
         men_d       = 1'b1;
         ren_d       = rd;
         wen_d       = !rd;
         bist_addr_d = pos_addr;
         din_d       = {DATA_W{elem_wr_bg(elem_q)}};
         rexp_d      = {DATA_W{elem_rd_bg(elem_q)}};
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
         op_elem_d   = elem_q;
`endif
         // All ops for one address before stepping; element change at terminal address.
         if (!op_idx_q && (elem_nops(elem_q) == 2'd2)) begin
            op_idx_d = 1'b1;
         end else begin
            op_idx_d = 1'b0;
            if (!pos_term) begin
               ag_step = 1'b1;
            end else if (elem_q == LastElem) begin
               fin_d = 1'b1;
            end else begin
               elem_d      = elem_q + 3'd1;
               ag_load     = 1'b1;
               ag_load_dir = elem_down(elem_q + 3'd1);
            end
         end
      end

      if (abort && (state_q inside {StSetup, StRun, StDrain})) begin
         state_d    = StIdle;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         pass_d     = 1'b0;
         en_d       = 1'b0;
         men_d      = 1'b0;
         wen_d      = 1'b0;
         ren_d      = 1'b0;
         cmp_vld_d  = 1'b0;
         fail_cnt_d = fail_cnt_q;
         ag_load    = 1'b0;
         ag_step    = 1'b0;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
         fail_elem_d = fail_elem_q;
         fail_addr_d = fail_addr_q;
         fail_syn_d  = fail_syn_q;
`endif
      end
   end

   always_ff @(posedge A_CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
         state_q     <= StIdle;
         elem_q      <= '0;
         op_idx_q    <= 1'b0;
         fin_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_cnt_q  <= '0;
         en_q        <= 1'b0;
         men_q       <= 1'b0;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         bist_addr_q <= '0;
         din_q       <= '0;
         rexp_q      <= '0;
         cmp_vld_q   <= 1'b0;
         cmp_exp_q   <= '0;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
         op_elem_q   <= '0;
         cmp_elem_q  <= '0;
         cmp_addr_q  <= '0;
         fail_elem_q <= '0;
         fail_addr_q <= '0;
         fail_syn_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         elem_q      <= elem_d;
         op_idx_q    <= op_idx_d;
         fin_q       <= fin_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_cnt_q  <= fail_cnt_d;
         en_q        <= en_d;
         men_q       <= men_d;
         wen_q       <= wen_d;
         ren_q       <= ren_d;
         bist_addr_q <= bist_addr_d;
         din_q       <= din_d;
         rexp_q      <= rexp_d;
         cmp_vld_q   <= cmp_vld_d;
         cmp_exp_q   <= cmp_exp_d;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
         op_elem_q   <= op_elem_d;
         cmp_elem_q  <= cmp_elem_d;
         cmp_addr_q  <= cmp_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_addr_q <= fail_addr_d;
         fail_syn_q  <= fail_syn_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail_cnt    = fail_cnt_q;
   assign A_BIST_EN   = en_q;
   assign A_BIST_MEN  = men_q;
   assign A_BIST_WEN  = wen_q;
   assign A_BIST_REN  = ren_q;
   assign A_BIST_ADDR = bist_addr_q;
   assign A_BIST_DIN  = din_q;
   assign A_BIST_BM   = '1;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
   assign fail_addr     = fail_addr_q;
   assign fail_elem     = fail_elem_q;
   assign fail_syndrome = fail_syn_q;
`endif

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for sram_march_bist_ctrl with a behavioural 256x16 SRAM and optional stuck-at fault.
module tb_sram_march_bist_ctrl;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned N       = 256;
   localparam int unsigned NOPS    = 2560;
   localparam int unsigned RUN_CYC = 2562;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              busy, done, pass;
   logic [CNT_W-1:0]  fail_cnt;
   logic              bist_en, men, wen, ren;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] din, bm;
   logic [DATA_W-1:0] dout = '0;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
   logic [ADDR_W-1:0] fail_addr;
   logic [2:0]        fail_elem;
   logic [DATA_W-1:0] fail_syndrome;
`endif

   logic [DATA_W-1:0] mem [N];
   logic              fault_en = 1'b0;
   logic [25:0]       trace [NOPS];
   int                n_ops = 0;
   int                n_both = 0;
   int                n_chk = 0;
   int                n_pass = 0;
   int                cyc_cnt = 0;
   int                ops0;

   always #5 clk = ~clk;

   sram_march_bist_ctrl #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
   ) dut (
      .A_CLK        (clk),
      .A_RST_N      (rst_n),
      .start        (start),
      .abort        (abort),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .fail_cnt     (fail_cnt),
      .A_BIST_EN    (bist_en),
      .A_BIST_MEN   (men),
      .A_BIST_WEN   (wen),
      .A_BIST_REN   (ren),
      .A_BIST_ADDR  (addr),
      .A_BIST_DIN   (din),
      .A_BIST_BM    (bm),
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
      .fail_addr    (fail_addr),
      .fail_elem    (fail_elem),
      .fail_syndrome(fail_syndrome),
`endif
      .A_DOUT       (dout)
   );

   // Behavioural macro: synchronous write and read, bit 3 stuck at 1 at 0x12 when faulted.
   always @(posedge clk) begin
      if (bist_en && men) begin
         if (wen) mem[addr] <= din;
         if (ren) dout <= (fault_en && addr == 8'h12) ? (mem[addr] | 16'h0008) : mem[addr];
      end
   end

   always @(posedge clk) begin
      if (men) begin
         if (n_ops < NOPS) trace[n_ops] = {wen, ren, addr, din};
         if (wen && ren) n_both = n_both + 1;
         n_ops = n_ops + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc_cnt = cyc_cnt + 1;
   endtask

   task automatic launch();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc_cnt = 0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_en", {31'd0, bist_en}, 32'd1);
   endtask

   task automatic wait_done();
      while (!done && cyc_cnt < 5000) tick();
      check("run_cycles", cyc_cnt, RUN_CYC);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_en", {31'd0, bist_en}, 32'd0);
   endtask

   initial begin
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_en_men", {30'd0, bist_en, men}, 32'd0);
      check("rst_bm", {16'd0, bm}, 32'h0000_ffff);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("idle_busy", {31'd0, busy}, 32'd0);

      // Clean run with op trace.
      ops0 = n_ops;
      launch();
      wait_done();
      check("clean_pass", {31'd0, pass}, 32'd1);
      check("clean_done", {31'd0, done}, 32'd1);
      check("clean_fcnt", {24'd0, fail_cnt}, 32'd0);
      check("op_count", n_ops - ops0, NOPS);
      check("op_both", n_both, 32'd0);
      check("op0", {6'd0, trace[0]}, {6'd0, 2'b10, 8'h00, 16'h0000});
      check("op1", {6'd0, trace[1]}, {6'd0, 2'b10, 8'h01, 16'h0000});
      check("op2", {6'd0, trace[2]}, {6'd0, 2'b10, 8'h02, 16'h0000});
      check("e1_rd", {6'd0, trace[256][25:16]}, {22'd0, 2'b01, 8'h00});
      check("e1_wr", {6'd0, trace[257]}, {6'd0, 2'b10, 8'h00, 16'hffff});
      check("e3_rd", {6'd0, trace[1280][25:16]}, {22'd0, 2'b01, 8'hff});
      check("e5_last", {6'd0, trace[2559][25:16]}, {22'd0, 2'b01, 8'hff});

      // Stuck-at-1 on bit 3 at 0x12.
      fault_en = 1'b1;
      launch();
      check("fault_fcnt_clr", {24'd0, fail_cnt}, 32'd0);
      wait_done();
      check("fault_fcnt", {24'd0, fail_cnt}, 32'd3);
      check("fault_pass", {31'd0, pass}, 32'd0);
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
      check("cap_addr", {24'd0, fail_addr}, 32'h12);
      check("cap_elem", {29'd0, fail_elem}, 32'd1);
      check("cap_syn", {16'd0, fail_syndrome}, 32'h0008);
`endif
      fault_en = 1'b0;

      // Abort 100 cycles after start, then a full rerun.
      launch();
      repeat (99) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_en_men", {30'd0, bist_en, men}, 32'd0);
      repeat (3) tick();
      check("abort_idle", {31'd0, busy}, 32'd0);
      launch();
      wait_done();
      check("rerun_pass", {31'd0, pass}, 32'd1);

      // Start while busy is ignored.
      launch();
      repeat (49) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done();
      check("busy_start_pass", {31'd0, pass}, 32'd1);

      // Start together with abort: abort wins, both mid-run and from DONE.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_done_busy", {31'd0, busy}, 32'd0);
      check("sa_done_done", {31'd0, done}, 32'd0);
      launch();
      repeat (20) tick();
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("sa_run_busy", {31'd0, busy}, 32'd0);
      check("sa_run_en", {31'd0, bist_en}, 32'd0);

      // Asynchronous reset mid-run.
      launch();
      repeat (500) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_en_men", {29'd0, bist_en, men, ren}, 32'd0);
      check("arst_addr", {24'd0, addr}, 32'd0);
      check("arst_bm", {16'd0, bm}, 32'h0000_ffff);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      check("post_rst_men", {30'd0, bist_en, men}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
